// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back write-allocate cache controller
//
// Purpose: serves one CPU read/write at a time from a direct-mapped array of
// 2**INDEX_BITS lines of 128 bits. Hits complete locally. On a miss, a dirty
// victim is written back first, then the line is refilled from memory.
//
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   cpu_req_addr/datain/rw/valid  CPU request (sampled only while cache_ready)
//   cpu_req_dataout             registered read word
//   cache_ready                 high only while idle
//   mem_req_addr/dataout/rw/valid  line-wide memory request (Moore outputs)
//   mem_req_datain/ready        memory refill data and completion
//   state_mode                  current FSM state (0 idle, 1 compare, 2 write-back, 3 allocate)
//   hit_count, miss_count       request statistics, present only with CACHE_STATS_EN
//
// Optional feature macro: CACHE_STATS_EN
module cache_controller #(
    parameter int INDEX_BITS = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  cpu_req_addr,
    input  logic [127:0] cpu_req_datain,
    input  logic         cpu_req_rw,
    input  logic         cpu_req_valid,
    output logic [31:0]  cpu_req_dataout,
    output logic         cache_ready,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_dataout,
    input  logic [127:0] mem_req_datain,
    output logic         mem_req_rw,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  state_mode
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_COMPARE    = 2'd1,
        S_WRITE_BACK = 2'd2,
        S_ALLOCATE   = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Latched request
    logic [27:0]         line_addr_q;
    logic [1:0]          word_q;
    logic                rw_q;
    logic [127:0]        wdata_q;
    logic [31:0]         dataout_q;

    // Line storage; only valid/dirty need reset
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [127:0]        data_mem [LINES];

    // Byte-offset bits carry no meaning for word/line accesses
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_req_addr[1:0];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  line_valid;
    logic                  line_dirty;
    logic [TAG_BITS-1:0]   line_tag;
    logic [127:0]          line_data;
    logic                  hit;
    logic                  mem_done;
    logic                  accept;
    logic                  hit_rd;
    logic                  hit_wr;
    logic                  refill;

    assign req_index  = line_addr_q[INDEX_BITS-1:0];
    assign req_tag    = line_addr_q[27:INDEX_BITS];
    assign line_valid = valid_q[req_index];
    assign line_dirty = dirty_q[req_index];
    assign line_tag   = tag_mem[req_index];
    assign line_data  = data_mem[req_index];
    assign hit        = line_valid && (line_tag == req_tag);

    // Handshake only counts while a request is actually presented
    assign mem_done = mem_req_valid && mem_req_ready;
    assign accept   = (state_q == S_IDLE) && cpu_req_valid;
    assign hit_rd   = (state_q == S_COMPARE) && hit && !rw_q;
    assign hit_wr   = (state_q == S_COMPARE) && hit && rw_q;
    assign refill   = (state_q == S_ALLOCATE) && mem_done;

    // Next-state and Moore output decode
    always_comb begin
        state_d         = state_q;
        cache_ready     = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_rw      = 1'b0;
        mem_req_addr    = 32'd0;
        mem_req_dataout = 128'd0;

        case (state_q)
            S_IDLE: begin
                cache_ready = 1'b1;
                if (cpu_req_valid) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    state_d = S_IDLE;
                end else if (line_valid && line_dirty) begin
                    state_d = S_WRITE_BACK;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                mem_req_valid   = 1'b1;
                mem_req_rw      = 1'b1;
                mem_req_addr    = {line_tag, req_index, 4'b0000};
                mem_req_dataout = line_data;
                if (mem_req_ready) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, 4'b0000};
                // Refill returns to COMPARE, which then resolves as a hit
                if (mem_req_ready) begin
                    state_d = S_COMPARE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_mode      = {30'd0, state_q};
    assign cpu_req_dataout = dataout_q;

    // Control state, valid/dirty bits and read result
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            dataout_q   <= 32'd0;
            line_addr_q <= 28'd0;
            word_q      <= 2'd0;
            rw_q        <= 1'b0;
            wdata_q     <= 128'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                line_addr_q <= cpu_req_addr[31:4];
                word_q      <= cpu_req_addr[3:2];
                rw_q        <= cpu_req_rw;
                wdata_q     <= cpu_req_datain;
            end
            if (hit_rd) begin
                dataout_q <= line_data[{word_q, 5'b00000} +: 32];
            end
            if (hit_wr) begin
                valid_q[req_index] <= 1'b1;
                dirty_q[req_index] <= 1'b1;
            end
            if (refill) begin
                valid_q[req_index] <= 1'b1;
                dirty_q[req_index] <= 1'b0;
            end
        end
    end

    // Tag/data arrays: no reset; a refill coinciding with reset is dropped
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (hit_wr) begin
                data_mem[req_index] <= wdata_q;
            end
            if (refill) begin
                data_mem[req_index] <= mem_req_datain;
                tag_mem[req_index]  <= req_tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Set on acceptance so only the first COMPARE of each request is counted
    logic        first_q;
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            first_q      <= 1'b0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            if (accept) begin
                first_q <= 1'b1;
            end else if (state_q == S_COMPARE) begin
                first_q <= 1'b0;
                if (first_q) begin
                    if (hit) begin
                        hit_count_q <= hit_count_q + 32'd1;
                    end else begin
                        miss_count_q <= miss_count_q + 32'd1;
                    end
                end
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized self-checking bench for cache_controller
module tb_cache_controller;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  cpu_req_addr;
    logic [127:0] cpu_req_datain;
    logic         cpu_req_rw;
    logic         cpu_req_valid;
    logic [31:0]  cpu_req_dataout;
    logic         cache_ready;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_dataout;
    logic [127:0] mem_req_datain;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  state_mode;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    cache_controller #(.INDEX_BITS(8)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_datain  (cpu_req_datain),
        .cpu_req_rw      (cpu_req_rw),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_dataout (cpu_req_dataout),
        .cache_ready     (cache_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_dataout (mem_req_dataout),
        .mem_req_datain  (mem_req_datain),
        .mem_req_rw      (mem_req_rw),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .state_mode      (state_mode)
`ifdef CACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-line contents plus a sparse main memory
    bit           m_valid [256];
    bit           m_dirty [256];
    logic [19:0]  m_tag   [256];
    logic [127:0] m_data  [256];
    logic [127:0] mem_model [logic [31:0]];
    logic [31:0]  exp_dout;
    int           exp_hits;
    int           exp_misses;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line_fetch(input logic [31:0] la);
        if (!mem_model.exists(la)) begin
            mem_model[la] = {$urandom, $urandom, $urandom, $urandom};
        end
        return mem_model[la];
    endfunction

    // Noise on inputs the DUT must ignore while busy
    task automatic garbage();
        cpu_req_valid  = 1'($urandom_range(0, 1));
        cpu_req_addr   = $urandom;
        cpu_req_rw     = 1'($urandom_range(0, 1));
        cpu_req_datain = {$urandom, $urandom, $urandom, $urandom};
        mem_req_datain = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic check_stats();
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_dout   = 32'd0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Issue one request at a negedge while idle; returns at a negedge once idle again
    task automatic do_req(input logic [31:0] addr, input bit rw, input logic [127:0] wd, input bit abort);
        logic [7:0]  idx;
        logic [19:0] tg;
        int          w;
        int          lat;
        bit          is_hit;
        logic [31:0] la;

        idx = addr[11:4];
        tg  = addr[31:12];
        w   = int'(addr[3:2]);
        la  = {addr[31:4], 4'b0000};

        check("ready_idle", cache_ready, 1'b1);
        cpu_req_addr   = addr;
        cpu_req_rw     = rw;
        cpu_req_datain = wd;
        cpu_req_valid  = 1'b1;
        mem_req_ready  = 1'b0;
        step();
        check("state_compare", state_mode, 32'd1);
        check("ready_busy", cache_ready, 1'b0);
        check("memvalid_compare", mem_req_valid, 1'b0);
        garbage();
        mem_req_ready = 1'($urandom_range(0, 1));

        is_hit = m_valid[idx] && (m_tag[idx] == tg);
        if (is_hit) exp_hits++;
        else exp_misses++;

        if (!is_hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                step();
                mem_req_ready = 1'b0;
                check("state_wb", state_mode, 32'd2);
                check("wb_valid", mem_req_valid, 1'b1);
                check("wb_rw", mem_req_rw, 1'b1);
                check("wb_addr", mem_req_addr, {m_tag[idx], idx, 4'b0000});
                check("wb_data", mem_req_dataout, m_data[idx]);
                mem_model[{m_tag[idx], idx, 4'b0000}] = m_data[idx];
                lat = $urandom_range(0, 3);
                for (int i = 0; i < lat; i++) begin
                    garbage();
                    step();
                    check("wb_hold", state_mode, 32'd2);
                end
                garbage();
                mem_req_ready = 1'b1;
                step();
                mem_req_ready = 1'b0;
            end else begin
                step();
                mem_req_ready = 1'b0;
            end
            check("state_alloc", state_mode, 32'd3);
            check("alloc_valid", mem_req_valid, 1'b1);
            check("alloc_rw", mem_req_rw, 1'b0);
            check("alloc_addr", mem_req_addr, la);
            lat = $urandom_range(0, 3);
            for (int i = 0; i < lat; i++) begin
                garbage();
                step();
                check("alloc_hold", state_mode, 32'd3);
            end
            if (abort) begin
                RESET          = 1'b1;
                mem_req_datain = {$urandom, $urandom, $urandom, $urandom};
                mem_req_ready  = 1'($urandom_range(0, 1));
                cpu_req_valid  = 1'b0;
                step();
                RESET         = 1'b0;
                mem_req_ready = 1'b0;
                model_reset();
                check("abort_state", state_mode, 32'd0);
                check("abort_memvalid", mem_req_valid, 1'b0);
                check("abort_ready", cache_ready, 1'b1);
                check("abort_dout", cpu_req_dataout, exp_dout);
                check_stats();
                return;
            end
            garbage();
            mem_req_datain = line_fetch(la);
            mem_req_ready  = 1'b1;
            step();
            mem_req_ready = 1'b0;
            check("state_recompare", state_mode, 32'd1);
            check("memvalid_recompare", mem_req_valid, 1'b0);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = mem_model[la];
            garbage();
        end

        if (rw) begin
            m_data[idx]  = wd;
            m_dirty[idx] = 1'b1;
        end else begin
            exp_dout = m_data[idx][w*32 +: 32];
        end
        step();
        cpu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        check("state_idle", state_mode, 32'd0);
        check("ready_done", cache_ready, 1'b1);
        check("memvalid_idle", mem_req_valid, 1'b0);
        check("memaddr_idle", mem_req_addr, 32'd0);
        check("dout", cpu_req_dataout, exp_dout);
        check_stats();
    endtask

    initial begin
        logic [127:0] all_a;
        logic [31:0]  addr;
        logic [7:0]   idx_list [4];

        all_a       = {32{4'hA}};
        idx_list[0] = 8'h00;
        idx_list[1] = 8'h01;
        idx_list[2] = 8'h7F;
        idx_list[3] = 8'hFF;

        RESET          = 1'b1;
        cpu_req_addr   = 32'd0;
        cpu_req_datain = 128'd0;
        cpu_req_rw     = 1'b0;
        cpu_req_valid  = 1'b0;
        mem_req_datain = 128'd0;
        mem_req_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_state", state_mode, 32'd0);
        check("rst_ready", cache_ready, 1'b1);
        check("rst_memvalid", mem_req_valid, 1'b0);
        check("rst_dout", cpu_req_dataout, 32'd0);
        check_stats();

        // Directed scenarios
        mem_model[32'h0000_1000] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        do_req(32'h0000_1004, 1'b0, 128'd0, 1'b0);
        check("tp_first_read", cpu_req_dataout, 32'h2222_2222);
        do_req(32'h0000_100C, 1'b0, 128'd0, 1'b0);
        check("tp_hit_read", cpu_req_dataout, 32'h4444_4444);
        do_req(32'h0000_1000, 1'b1, all_a, 1'b0);
        do_req(32'h0000_1000, 1'b0, 128'd0, 1'b0);
        check("tp_read_after_write", cpu_req_dataout, 32'hAAAA_AAAA);
        do_req(32'h0010_1000, 1'b0, 128'd0, 1'b0);
        do_req(32'h0020_1000, 1'b0, 128'd0, 1'b1);
        do_req(32'h0000_1004, 1'b0, 128'd0, 1'b0);
        check("tp_reread_after_abort", cpu_req_dataout, 32'hAAAA_AAAA);

        // Random traffic over a few conflicting tags and boundary indices
        for (int n = 0; n < 200; n++) begin
            addr = {20'($urandom_range(0, 3)), idx_list[$urandom_range(0, 3)],
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(addr, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
